// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding and byte-lane geometry.
// Imported by the loader top so other blocks can decode its state consistently.
package prog_loader_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRecv  = 2'd1,
      StWrite = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam int unsigned NumLanes = 4;
   localparam int unsigned LaneW    = $clog2(NumLanes);

   typedef logic [LaneW-1:0] lane_t;

   localparam lane_t LastLane = lane_t'(NumLanes - 1);

endpackage

// File: rtl/prog_loader.sv
// Streams a little-endian byte image into instruction memory one 32-bit word at a time
// and holds the core in reset until a complete image has been written.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             imem_we,
   output logic [31:0]      imem_addr,
   output logic [31:0]      imem_wdata,
   output logic             core_rst_n,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned AddrPad = 32 - CNT_W - LaneW;
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_words_q, num_words_d;
   logic [CNT_W-1:0] word_idx_q, word_idx_d;
   lane_t            byte_cnt_q, byte_cnt_d;
   logic [23:0]      shift_q, shift_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             err_q, err_d;
   logic             start_ok;

   assign start_ok = (num_words != '0) && (32'(num_words) <= DEPTH);

   always_comb begin
      state_d     = state_q;
      num_words_d = num_words_q;
      word_idx_d  = word_idx_q;
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               if (start_ok) begin
                  state_d     = StRecv;
                  err_d       = 1'b0;
                  num_words_d = num_words;
                  word_idx_d  = '0;
                  byte_cnt_d  = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         StRecv: begin
            if (byte_valid) begin
               byte_cnt_d = byte_cnt_q + lane_t'(1);
               case (byte_cnt_q)
                  2'd0:    shift_d[7:0]   = byte_data;
                  2'd1:    shift_d[15:8]  = byte_data;
                  2'd2:    shift_d[23:16] = byte_data;
                  default: shift_d        = shift_q;
               endcase
               // Output word/address are loaded here so they are stable for the WRITE cycle
               // and hold afterwards while the next word is collected in shift_q.
               if (byte_cnt_q == LastLane) begin
                  state_d    = StWrite;
                  byte_cnt_d = '0;
                  wdata_d    = {byte_data, shift_q};
                  addr_d     = {{AddrPad{1'b0}}, word_idx_q, {LaneW{1'b0}}};
               end
            end
         end

         StWrite: begin
            if (word_idx_q == num_words_q - CntOne) begin
               state_d = StDone;
            end else begin
               state_d    = StRecv;
               word_idx_d = word_idx_q + CntOne;
               byte_cnt_d = '0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         num_words_q <= '0;
         word_idx_q  <= '0;
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_words_q <= num_words_d;
         word_idx_q  <= word_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
      end
   end

   assign byte_ready = (state_q == StRecv);
   assign imem_we    = (state_q == StWrite);
   assign busy       = (state_q == StRecv) || (state_q == StWrite);
   assign done       = (state_q == StDone);
   assign core_rst_n = (state_q == StDone);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: reset, back-to-back and stalled loads,
// start rejection, reload from DONE and mid-load reset.
module tb_prog_loader;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned CNT_W = 7;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] num_words;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_ready;
   logic             imem_we;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_wdata;
   logic             core_rst_n;
   logic             busy;
   logic             done;
   logic             err;

   int checks   = 0;
   int failures = 0;
   int wr_n     = 0;
   int busy_low = 0;
   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];

   prog_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Write log, sampled mid-cycle
   always @(negedge clk) begin
      if (imem_we) begin
         if (wr_n < 16) begin
            wr_addr[wr_n] = imem_addr;
            wr_data[wr_n] = imem_wdata;
         end
         wr_n = wr_n + 1;
      end
   end

   task automatic do_start(input logic [CNT_W-1:0] n);
      @(posedge clk); #1;
      start     = 1'b1;
      num_words = n;
      @(posedge clk); #1;
      start     = 1'b0;
      num_words = '0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
         if (!busy) busy_low++;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      guard      = 0;
      while (!byte_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (!byte_ready) begin
         failures++;
         $display("FAIL send_byte_ready: byte_ready=%b required 1 within 50 cycles", byte_ready);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i;
      i = 0;
      while (!done && i < 60) begin
         @(posedge clk); #1;
         i++;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_timeout: done=%b required 1 within 60 cycles", name, done);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #3;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
      #12;
      checks++;
      if ({byte_ready, imem_we, core_rst_n, busy, done, err} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {byte_ready, imem_we, core_rst_n, busy, done, err});
      end
      checks++;
      if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus: addr=%h data=%h required 0/0", imem_addr, imem_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_err_idle();
      do_start(7'd0);
      checks++;
      if ({err, busy, byte_ready, core_rst_n, done} !== 5'b10000) begin
         failures++;
         $display("FAIL err_zero: err/busy/rdy/crst/done=%b required 10000",
                  {err, busy, byte_ready, core_rst_n, done});
      end
      do_start(7'(DEPTH + 1));
      checks++;
      if ({err, busy, byte_ready, core_rst_n, done} !== 5'b10000) begin
         failures++;
         $display("FAIL err_over: err/busy/rdy/crst/done=%b required 10000",
                  {err, busy, byte_ready, core_rst_n, done});
      end
      // DEPTH itself is a legal count and clears err
      do_start(7'(DEPTH));
      checks++;
      if ({err, busy, byte_ready} !== 3'b011) begin
         failures++;
         $display("FAIL start_depth: err/busy/rdy=%b required 011", {err, busy, byte_ready});
      end
      pulse_reset();
   endtask

   task automatic test_back_to_back();
      logic [7:0] img [8];
      int base;
      int done_cyc;
      img = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      base     = wr_n;
      done_cyc = 0;
      do_start(7'd2);
      fork
         begin
            for (int i = 0; i < 8; i++) send_byte(img[i], 0);
         end
         begin
            int c;
            c = 1;
            while (done_cyc == 0 && c <= 30) begin
               if (done) done_cyc = c;
               @(posedge clk); #1;
               c++;
            end
         end
      join
      checks++;
      if (done_cyc != 11) begin
         failures++;
         $display("FAIL b2b_latency: done seen at cycle %0d required 11", done_cyc);
      end
      checks++;
      if (wr_n - base != 2) begin
         failures++;
         $display("FAIL b2b_count: writes=%0d required 2", wr_n - base);
      end else begin
         checks++;
         if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h00500013) begin
            failures++;
            $display("FAIL b2b_word0: addr=%h data=%h required 00000000/00500013",
                     wr_addr[base], wr_data[base]);
         end
         checks++;
         if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00100093) begin
            failures++;
            $display("FAIL b2b_word1: addr=%h data=%h required 00000004/00100093",
                     wr_addr[base+1], wr_data[base+1]);
         end
      end
      checks++;
      if ({core_rst_n, done, busy, byte_ready, imem_we} !== 5'b11000) begin
         failures++;
         $display("FAIL b2b_done: crst/done/busy/rdy/we=%b required 11000",
                  {core_rst_n, done, busy, byte_ready, imem_we});
      end
      checks++;
      if (imem_addr !== 32'h4 || imem_wdata !== 32'h00100093) begin
         failures++;
         $display("FAIL b2b_hold: addr=%h data=%h required 00000004/00100093",
                  imem_addr, imem_wdata);
      end
   endtask

   task automatic test_err_from_done();
      do_start(7'd0);
      checks++;
      if ({err, done, core_rst_n, busy} !== 4'b1110) begin
         failures++;
         $display("FAIL err_done: err/done/crst/busy=%b required 1110",
                  {err, done, core_rst_n, busy});
      end
   endtask

   task automatic test_reload();
      int base;
      base = wr_n;
      do_start(7'd1);
      checks++;
      if ({core_rst_n, done, byte_ready, err} !== 4'b0010) begin
         failures++;
         $display("FAIL reload_enter: crst/done/rdy/err=%b required 0010",
                  {core_rst_n, done, byte_ready, err});
      end
      send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
      wait_done("reload");
      checks++;
      if (core_rst_n !== 1'b1) begin
         failures++;
         $display("FAIL reload_release: core_rst_n=%b required 1", core_rst_n);
      end
      checks++;
      if (wr_n - base != 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hEFBEADDE) begin
         failures++;
         $display("FAIL reload_write: n=%0d addr=%h data=%h required 1/00000000/efbeadde",
                  wr_n - base, wr_addr[base], wr_data[base]);
      end
   endtask

   task automatic test_stalls();
      int base;
      base     = wr_n;
      busy_low = 0;
      do_start(7'd1);
      send_byte(8'h11, 3); send_byte(8'h22, 3); send_byte(8'h33, 3); send_byte(8'h44, 3);
      wait_done("stall");
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy_low != 0) begin
         failures++;
         $display("FAIL stall_busy: busy low %0d times required 0", busy_low);
      end
      checks++;
      if (wr_n - base != 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h44332211) begin
         failures++;
         $display("FAIL stall_write: n=%0d addr=%h data=%h required 1/00000000/44332211",
                  wr_n - base, wr_addr[base], wr_data[base]);
      end
   endtask

   task automatic test_start_ignored();
      int base;
      base = wr_n;
      do_start(7'd2);
      send_byte(8'h01, 0); send_byte(8'h02, 0);
      do_start(7'd0);
      checks++;
      if ({err, busy, byte_ready} !== 3'b011) begin
         failures++;
         $display("FAIL ign_start: err/busy/rdy=%b required 011", {err, busy, byte_ready});
      end
      send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h05, 0);
      send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
      wait_done("ign");
      checks++;
      if (wr_n - base != 2) begin
         failures++;
         $display("FAIL ign_count: writes=%0d required 2", wr_n - base);
      end else begin
         checks++;
         if (wr_data[base] !== 32'h04030201 || wr_addr[base+1] !== 32'h4 ||
             wr_data[base+1] !== 32'h08070605) begin
            failures++;
            $display("FAIL ign_data: w0=%h a1=%h w1=%h required 04030201/00000004/08070605",
                     wr_data[base], wr_addr[base+1], wr_data[base+1]);
         end
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL ign_err: err=%b required 0", err);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      do_start(7'd2);
      send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0); send_byte(8'hA4, 0);
      send_byte(8'hB1, 0); send_byte(8'hB2, 0);
      base = wr_n;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({byte_ready, imem_we, core_rst_n, busy, done, err} !== 6'b0 ||
          imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL midrst_outputs: ctrl=%b addr=%h data=%h required 000000/0/0",
                  {byte_ready, imem_we, core_rst_n, busy, done, err}, imem_addr, imem_wdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (wr_n != base || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_quiet: writes=%0d busy=%b required 0/0", wr_n - base, busy);
      end
      do_start(7'd1);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
      wait_done("midrst");
      checks++;
      if (wr_n - base != 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hDDCCBBAA) begin
         failures++;
         $display("FAIL midrst_write: n=%0d addr=%h data=%h required 1/00000000/ddccbbaa",
                  wr_n - base, wr_addr[base], wr_data[base]);
      end
   endtask

   initial begin
      test_reset();
      test_err_idle();
      test_back_to_back();
      test_err_from_done();
      test_reload();
      test_stalls();
      test_start_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
